// File: rtl/icache_pkg.sv
// icache_pkg: shared defaults, derived address-field widths and FSM state
// encoding for the instruction-cache refill block.
//   DEF_LINES / DEF_WORDS : default geometry (direct-mapped lines, 32-bit words per line)
//   OFFSET_W / INDEX_W / TAG_W : iaddr field widths at the default geometry
//   state_e : controller states
package icache_pkg;

  localparam int DEF_LINES = 64;
  localparam int DEF_WORDS = 4;
  localparam int OFFSET_W  = $clog2(DEF_WORDS);
  localparam int INDEX_W   = $clog2(DEF_LINES);
  localparam int TAG_W     = 32 - INDEX_W - OFFSET_W - 2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_REFILL = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/icache_ram.sv
// icache_ram: single-port tag + data store for the instruction cache.
// One shared address serves both the synchronous read and the writes; each
// data word has its own write enable so refill beats land one at a time.
// Contents are deliberately not reset.
//   clk     : rising-edge clock
//   en      : read enable; rtag/rdata update on the following edge
//   addr    : line index
//   we_word : per-word write enables, wdata written to the selected words
//   we_tag  : tag write enable, wtag written
//   rtag    : registered tag read
//   rdata   : registered line read, word 0 in the low 32 bits
module icache_ram
  import icache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS,
  parameter int TAG_B = TAG_W
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [$clog2(LINES)-1:0] addr,
  input  logic [WORDS-1:0]         we_word,
  input  logic [31:0]              wdata,
  input  logic                     we_tag,
  input  logic [TAG_B-1:0]         wtag,
  output logic [TAG_B-1:0]         rtag,
  output logic [WORDS*32-1:0]      rdata
);

  logic [TAG_B-1:0] tag_mem [LINES];

  always_ff @(posedge clk) begin
    if (we_tag) tag_mem[addr] <= wtag;
    if (en)     rtag <= tag_mem[addr];
  end

  // One narrow array per word so each word can be written independently.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      logic [31:0] mem [LINES];
      logic [31:0] rd_q;

      always_ff @(posedge clk) begin
        if (we_word[gi]) mem[addr] <= wdata;
        if (en)          rd_q <= mem[addr];
      end

      assign rdata[gi*32 +: 32] = rd_q;
    end
  endgenerate

endmodule

// File: rtl/icache_fill.sv
// icache_fill: direct-mapped, read-only instruction cache with line refill.
// A fetch accepted at an edge is answered in the next cycle: a hit returns
// the word with stall_req low; a miss raises stall_req, refills the whole
// line from backing memory beat by beat, then presents the requested word
// for one RESP cycle.
//   clk, rst             : clock, asynchronous active-high reset
//   ice, iaddr           : fetch enable and byte address (bits [1:0] ignored)
//   inst, stall_req      : fetched instruction, pipeline freeze request
//   inv                  : one-cycle pulse invalidating every line
//   mem_req, mem_addr    : refill request and line-aligned address
//   mem_rvalid, mem_rdata: refill beats, word 0 first
module icache_fill
  import icache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ice,
  input  logic [31:0] iaddr,
  output logic [31:0] inst,
  output logic        stall_req,
  input  logic        inv,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_B = 30 - IDX_W - OFF_W;

  state_e           state_q, state_d;
  logic             req_v_q, req_v_d;
  logic [29:0]      req_addr_q, req_addr_d;   // word address of the pending fetch
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [31:0]      word_q, word_d;           // requested word captured during refill
  logic             mem_req_q, mem_req_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic             inv_seen_q, inv_seen_d;   // inv arrived while refilling
  logic [LINES-1:0] valid_q, valid_d;

  logic [OFF_W-1:0]    req_off;
  logic [IDX_W-1:0]    req_idx;
  logic [TAG_B-1:0]    req_tag;
  logic [TAG_B-1:0]    rd_tag;
  logic [WORDS*32-1:0] rd_data;
  logic [31:0]         rd_word;
  logic [WORDS-1:0]    we_word;
  logic [IDX_W-1:0]    ram_addr;
  logic                hit, miss, beat, last_beat, accept;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^iaddr[1:0];

  assign req_off = req_addr_q[OFF_W-1:0];
  assign req_idx = req_addr_q[OFF_W +: IDX_W];
  assign req_tag = req_addr_q[29 -: TAG_B];
  assign rd_word = rd_data[req_off*32 +: 32];

  assign hit       = req_v_q && valid_q[req_idx] && (rd_tag == req_tag);
  assign miss      = (state_q == ST_RUN) && req_v_q && !hit;
  assign beat      = (state_q == ST_REFILL) && mem_rvalid;
  assign last_beat = beat && (cnt_q == OFF_W'(WORDS - 1));
  // A missing request is held (the pipeline is frozen), so nothing new is
  // accepted in the detect cycle.
  assign accept    = ice && (((state_q == ST_RUN) && !miss) || (state_q == ST_RESP));

  // The single RAM port follows the refill line while refilling, otherwise
  // it looks up the incoming fetch address.
  assign ram_addr = (state_q == ST_REFILL) ? req_idx : iaddr[OFF_W+2 +: IDX_W];

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_we
      assign we_word[gi] = beat && (cnt_q == OFF_W'(gi));
    end
  endgenerate

  icache_ram #(
    .LINES (LINES),
    .WORDS (WORDS),
    .TAG_B (TAG_B)
  ) u_ram (
    .clk     (clk),
    .en      (accept),
    .addr    (ram_addr),
    .we_word (we_word),
    .wdata   (mem_rdata),
    .we_tag  (last_beat),
    .wtag    (req_tag),
    .rtag    (rd_tag),
    .rdata   (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    req_v_d    = req_v_q;
    req_addr_d = req_addr_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    inv_seen_d = inv_seen_q;
    valid_d    = valid_q;

    unique case (state_q)
      ST_RUN: begin
        if (miss) begin
          state_d    = ST_REFILL;
          mem_req_d  = 1'b1;
          mem_addr_d = {req_addr_q[29:OFF_W], {(OFF_W + 2){1'b0}}};
          cnt_d      = '0;
          inv_seen_d = 1'b0;
        end else begin
          req_v_d = ice;
          if (ice) req_addr_d = iaddr[31:2];
        end
      end
      ST_REFILL: begin
        if (beat) begin
          cnt_d = cnt_q + OFF_W'(1);
          if (cnt_q == req_off) word_d = mem_rdata;
          if (last_beat) begin
            state_d   = ST_RESP;
            mem_req_d = 1'b0;
            if (!inv_seen_q && !inv) valid_d[req_idx] = 1'b1;
          end
        end
        if (inv) inv_seen_d = 1'b1;
      end
      ST_RESP: begin
        state_d = ST_RUN;
        req_v_d = ice;
        if (ice) req_addr_d = iaddr[31:2];
      end
      default: state_d = ST_RUN;
    endcase

    // Invalidate overrides any valid bit set at the same edge.
    if (inv) valid_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      req_v_q    <= 1'b0;
      req_addr_q <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      inv_seen_q <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_v_q    <= req_v_d;
      req_addr_q <= req_addr_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      inv_seen_q <= inv_seen_d;
      valid_q    <= valid_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign stall_req = miss || (state_q == ST_REFILL);

  always_comb begin
    inst = '0;
    if (state_q == ST_RESP)                inst = word_q;
    else if ((state_q == ST_RUN) && hit)   inst = rd_word;
  end

endmodule
